// File: rtl/vga_scan_gen_if.sv
// Scan-timing bus between vga_scan_gen and its consumers (draw layer / DAC).
// Optional frame counter signal is present only when VGA_SCAN_FRAME_CNT_EN is defined.
interface vga_scan_gen_if;
  logic [9:0]  horz;
  logic [9:0]  vert;
  logic        pix_en;
  logic        frame_start;
  logic [7:0]  img_in;
  logic [7:0]  rgb;
  logic        hsync;
  logic        vsync;
`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  // Scan generator side.
  modport master (
    input  img_in,
    output horz,
    output vert,
    output pix_en,
    output frame_start,
    output rgb,
    output hsync,
    output vsync
`ifdef VGA_SCAN_FRAME_CNT_EN
    ,
    output frame_cnt
`endif
  );

  // Draw layer / display side.
  modport slave (
    output img_in,
    input  horz,
    input  vert,
    input  pix_en,
    input  frame_start,
    input  rgb,
    input  hsync,
    input  vsync
`ifdef VGA_SCAN_FRAME_CNT_EN
    ,
    input  frame_cnt
`endif
  );
endinterface

// File: rtl/vga_scan_gen.sv
// VGA scan-timing generator (640x480@60 by default).
// Produces pixel-rate strobes, horz/vert coordinates, and sync/pixel outputs
// aligned to the draw layer's read latency (PIPE_DLY).
// Optional: define VGA_SCAN_FRAME_CNT_EN to add a 16-bit frame counter output.
module vga_scan_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic           clk,
  input  logic           reset,
  vga_scan_gen_if.master bus
);

  localparam int unsigned HTotal = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast   = 10'(HTotal - 1);
  localparam logic [9:0] VLast   = 10'(VTotal - 1);
  localparam logic [9:0] HVis    = 10'(H_VIS);
  localparam logic [9:0] VVis    = 10'(V_VIS);
  localparam logic [9:0] HsFirst = 10'(H_VIS + H_FP);
  localparam logic [9:0] HsLast  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VsFirst = 10'(V_VIS + V_FP);
  localparam logic [9:0] VsLast  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [3:0] DivLast = 4'(CLK_DIV - 1);

  // StWait: no pixel strobe seen since reset; the first strobe marks (0,0)
  // without advancing. StScan: every strobe advances the raster position.
  typedef enum logic [0:0] {StWait, StScan} state_e;

  state_e      state_q, state_d;
  logic [3:0]  div_q, div_d;
  logic [9:0]  horz_q, horz_d;
  logic [9:0]  vert_q, vert_d;
  logic        pix_en_q, pix_en_d;
  logic        frame_start_q, frame_start_d;
  logic        tick;

  logic        blank_r, hs_r, vs_r;
  logic        blank_dly, hs_dly, vs_dly;
  logic [7:0]  rgb_q;
  logic        hsync_q, vsync_q;

  // Pixel-rate divider: tick on the last system clock of each pixel period.
  always_comb begin
    tick  = (div_q == DivLast);
    div_d = tick ? 4'd0 : div_q + 4'd1;
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 4'd0;
    end else begin
      div_q <= div_d;
    end
  end

  // Raster FSM: next position, pixel strobe and frame-start strobe.
  always_comb begin
    state_d       = state_q;
    horz_d        = horz_q;
    vert_d        = vert_q;
    pix_en_d      = tick;
    frame_start_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        StWait: begin
          state_d       = StScan;
          frame_start_d = 1'b1;
        end
        StScan: begin
          if (horz_q == HLast) begin
            horz_d = 10'd0;
            if (vert_q == VLast) begin
              vert_d        = 10'd0;
              frame_start_d = 1'b1;
            end else begin
              vert_d = vert_q + 10'd1;
            end
          end else begin
            horz_d = horz_q + 10'd1;
          end
        end
        default: state_d = StWait;
      endcase
    end
  end

  // Raster state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StWait;
      horz_q        <= 10'd0;
      vert_q        <= 10'd0;
      pix_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      horz_q        <= horz_d;
      vert_q        <= vert_d;
      pix_en_q      <= pix_en_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Count frame wraps only; the strobe leaving StWait is frame 0.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d && (state_q == StScan)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

  // Undelayed blank/sync decode from the current raster position.
  always_comb begin
    blank_r = (horz_q >= HVis) || (vert_q >= VVis);
    hs_r    = !((horz_q >= HsFirst) && (horz_q <= HsLast));
    vs_r    = !((vert_q >= VsFirst) && (vert_q <= VsLast));
  end

  // Delay line matching the draw layer's read latency; runs every clk.
  if (PIPE_DLY == 0) begin : g_no_dly
    assign blank_dly = blank_r;
    assign hs_dly    = hs_r;
    assign vs_dly    = vs_r;
  end else begin : g_dly
    logic [PIPE_DLY-1:0] blank_sr_q, hs_sr_q, vs_sr_q;

    // Shift decoded blank/sync along with the outstanding pixel reads.
    always_ff @(posedge clk) begin
      if (reset) begin
        blank_sr_q <= '1;
        hs_sr_q    <= '1;
        vs_sr_q    <= '1;
      end else begin
        blank_sr_q[0] <= blank_r;
        hs_sr_q[0]    <= hs_r;
        vs_sr_q[0]    <= vs_r;
        for (int i = 1; i < PIPE_DLY; i++) begin
          blank_sr_q[i] <= blank_sr_q[i-1];
          hs_sr_q[i]    <= hs_sr_q[i-1];
          vs_sr_q[i]    <= vs_sr_q[i-1];
        end
      end
    end

    assign blank_dly = blank_sr_q[PIPE_DLY-1];
    assign hs_dly    = hs_sr_q[PIPE_DLY-1];
    assign vs_dly    = vs_sr_q[PIPE_DLY-1];
  end

  // Output stage: pixel blanking and sync registered together so they stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= 8'h00;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= blank_dly ? 8'h00 : bus.img_in;
      hsync_q <= hs_dly;
      vsync_q <= vs_dly;
    end
  end

  assign bus.horz        = horz_q;
  assign bus.vert        = vert_q;
  assign bus.pix_en      = pix_en_q;
  assign bus.frame_start = frame_start_q;
  assign bus.rgb         = rgb_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Self-checking bench for vga_scan_gen: three instances (default timing,
// reduced timing with CLK_DIV=3/PIPE_DLY=2, reduced timing with CLK_DIV=1/PIPE_DLY=0)
// checked against a closed-form raster model driven by clocks-since-reset.
module tb_vga_scan_gen;

  typedef struct packed {
`ifdef VGA_SCAN_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif
    logic [9:0]  horz;
    logic [9:0]  vert;
    logic        pix_en;
    logic        frame_start;
    logic [7:0]  rgb;
    logic        hsync;
    logic        vsync;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b, rst_s, rst_o;
  bit   rand_img = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  vga_scan_gen_if bus_b ();
  vga_scan_gen_if bus_s ();
  vga_scan_gen_if bus_o ();

  vga_scan_gen u_big (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  vga_scan_gen #(
    .CLK_DIV (3), .H_VIS (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_VIS (4), .V_FP (1), .V_SYNC (2), .V_BP (1), .PIPE_DLY (2)
  ) u_small (
    .clk   (clk),
    .reset (rst_s),
    .bus   (bus_s)
  );

  vga_scan_gen #(
    .CLK_DIV (1), .H_VIS (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_VIS (4), .V_FP (1), .V_SYNC (2), .V_BP (1), .PIPE_DLY (0)
  ) u_one (
    .clk   (clk),
    .reset (rst_o),
    .bus   (bus_o)
  );

  snap_t obs_b, obs_s, obs_o;
  assign obs_b = {
`ifdef VGA_SCAN_FRAME_CNT_EN
    bus_b.frame_cnt,
`endif
    bus_b.horz, bus_b.vert, bus_b.pix_en, bus_b.frame_start, bus_b.rgb, bus_b.hsync, bus_b.vsync};
  assign obs_s = {
`ifdef VGA_SCAN_FRAME_CNT_EN
    bus_s.frame_cnt,
`endif
    bus_s.horz, bus_s.vert, bus_s.pix_en, bus_s.frame_start, bus_s.rgb, bus_s.hsync, bus_s.vsync};
  assign obs_o = {
`ifdef VGA_SCAN_FRAME_CNT_EN
    bus_o.frame_cnt,
`endif
    bus_o.horz, bus_o.vert, bus_o.pix_en, bus_o.frame_start, bus_o.rgb, bus_o.hsync, bus_o.vsync};

  // Model inputs: clocks since the last reset edge and the pixel sampled at each edge.
  int         t_b = 0, t_s = 0, t_o = 0;
  logic [7:0] img_b_s = 8'h00, img_s_s = 8'h00, img_o_s = 8'h00;

  always @(posedge clk) begin
    t_b     <= rst_b ? 0 : t_b + 1;
    t_s     <= rst_s ? 0 : t_s + 1;
    t_o     <= rst_o ? 0 : t_o + 1;
    img_b_s <= bus_b.img_in;
    img_s_s <= bus_s.img_in;
    img_o_s <= bus_o.img_in;
  end

  // Expected outputs t clocks after reset release. Pixel index p starts at the
  // first strobe (t == cd); outputs reflect the position dly+1 clocks earlier.
  function automatic snap_t model(int t, int cd, int hv, int hfp, int hsy, int hbp,
                                  int vv, int vfp, int vsy, int vbp, int dly,
                                  logic [7:0] img);
    snap_t e;
    int ht, vt, p, s, ps, hh, vl;
    ht = hv + hfp + hsy + hbp;
    vt = vv + vfp + vsy + vbp;
    e  = '0;
    p  = (t >= cd) ? t / cd - 1 : 0;
    e.horz        = 10'(p % ht);
    e.vert        = 10'((p / ht) % vt);
    e.pix_en      = (t >= cd) && (t % cd == 0);
    e.frame_start = e.pix_en && (p % (ht * vt) == 0);
`ifdef VGA_SCAN_FRAME_CNT_EN
    e.frame_cnt   = 16'((p / (ht * vt)) % 65536);
`endif
    if (t - dly < 1) begin
      e.rgb   = 8'h00;
      e.hsync = 1'b1;
      e.vsync = 1'b1;
    end else begin
      s  = t - dly - 1;
      ps = (s >= cd) ? s / cd - 1 : 0;
      hh = ps % ht;
      vl = (ps / ht) % vt;
      e.rgb   = (hh >= hv || vl >= vv) ? 8'h00 : img;
      e.hsync = !(hh >= hv + hfp && hh < hv + hfp + hsy);
      e.vsync = !(vl >= vv + vfp && vl < vv + vfp + vsy);
    end
    return e;
  endfunction

  function automatic snap_t exp_b();
    return model(t_b, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1, img_b_s);
  endfunction
  function automatic snap_t exp_s();
    return model(t_s, 3, 8, 2, 3, 2, 4, 1, 2, 1, 2, img_s_s);
  endfunction
  function automatic snap_t exp_o();
    return model(t_o, 1, 8, 2, 3, 2, 4, 1, 2, 1, 0, img_o_s);
  endfunction

  // Advance one clock; new pixel data is driven at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (rand_img) begin
      bus_b.img_in = 8'($urandom);
      bus_s.img_in = 8'($urandom);
      bus_o.img_in = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    snap_t r;
    r = '0;
    r.hsync = 1'b1;
    r.vsync = 1'b1;
    rst_b = 1'b1; rst_s = 1'b1; rst_o = 1'b1;
    repeat (3) tick();
    tests++;
    if (obs_b !== r) begin fails++; $display("FAIL reset_big: got %h want %h", obs_b, r); end
    tests++;
    if (obs_s !== r) begin fails++; $display("FAIL reset_small: got %h want %h", obs_s, r); end
    tests++;
    if (obs_o !== r) begin fails++; $display("FAIL reset_one: got %h want %h", obs_o, r); end
    rst_b = 1'b0; rst_s = 1'b0; rst_o = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++;
      if (bus_b.pix_en !== (k == 4) || bus_b.frame_start !== (k == 4)) begin
        fails++;
        $display("FAIL first_strobe clk%0d: pix_en=%b frame_start=%b want %b", k,
                 bus_b.pix_en, bus_b.frame_start, k == 4);
      end
      tests++;
      if (bus_b.horz !== 10'd0 || bus_b.vert !== 10'd0) begin
        fails++;
        $display("FAIL first_pos clk%0d: got (%0d,%0d) want (0,0)", k, bus_b.horz, bus_b.vert);
      end
      if (k == 1) begin
        tests++;
        if (bus_b.rgb !== 8'h00 || bus_b.hsync !== 1'b1 || bus_b.vsync !== 1'b1) begin
          fails++;
          $display("FAIL release_out: rgb=%h hs=%b vs=%b want 00 1 1",
                   bus_b.rgb, bus_b.hsync, bus_b.vsync);
        end
      end
    end
  endtask

  task automatic test_big_scan();
    for (int i = 0; i < 7000; i++) begin
      tick();
      tests++;
      if (obs_b !== exp_b()) begin
        fails++;
        $display("FAIL big_scan t=%0d: got %h want %h", t_b, obs_b, exp_b());
      end
    end
  endtask

  task automatic test_hsync_line();
    int n, c0, c1, low;
    n = 0;
    while (!(bus_b.horz == 10'd656 && bus_b.pix_en) && n < 4000) begin tick(); n++; end
    tests++;
    if (n >= 4000) begin fails++; $display("FAIL hs_wait656: got timeout want horz=656"); return; end
    c0 = cyc;
    n = 0;
    while (bus_b.hsync !== 1'b0 && n < 20) begin tick(); n++; end
    tests++;
    if (cyc - c0 != 2) begin
      fails++;
      $display("FAIL hs_latency: got %0d want 2", cyc - c0);
    end
    c1 = cyc;
    low = 0;
    while (bus_b.hsync === 1'b0 && low < 1000) begin tick(); low++; end
    tests++;
    if (low != 384) begin fails++; $display("FAIL hs_width: got %0d want 384", low); end
    n = 0;
    while (bus_b.hsync !== 1'b0 && n < 4000) begin tick(); n++; end
    tests++;
    if (cyc - c1 != 3200) begin
      fails++;
      $display("FAIL hs_period: got %0d want 3200", cyc - c1);
    end
  endtask

  task automatic test_blank_ff();
    int ff_b, ff_s;
    rand_img = 1'b0;
    bus_b.img_in = 8'hFF; bus_s.img_in = 8'hFF; bus_o.img_in = 8'hFF;
    ff_b = 0;
    ff_s = 0;
    for (int i = 0; i < 3200; i++) begin
      tick();
      if (bus_b.rgb === 8'hFF) ff_b++;
      if (i < 360 && bus_s.rgb === 8'hFF) ff_s++;
      tests++;
      if (obs_b !== exp_b()) begin
        fails++;
        $display("FAIL blank_big t=%0d: got %h want %h", t_b, obs_b, exp_b());
      end
    end
    tests++;
    if (ff_b != 2560) begin fails++; $display("FAIL blank_line_cnt: got %0d want 2560", ff_b); end
    tests++;
    if (ff_s != 96) begin fails++; $display("FAIL blank_frame_cnt: got %0d want 96", ff_s); end
    rand_img = 1'b1;
  endtask

  task automatic test_small_frames();
    int fs_cnt, vs_low;
    fs_cnt = 0;
    vs_low = 0;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (i < 360) begin
        if (bus_s.frame_start === 1'b1) fs_cnt++;
        if (bus_s.vsync === 1'b0) vs_low++;
      end
      tests++;
      if (obs_s !== exp_s()) begin
        fails++;
        $display("FAIL small_scan t=%0d: got %h want %h", t_s, obs_s, exp_s());
      end
      tests++;
      if (obs_o !== exp_o()) begin
        fails++;
        $display("FAIL div1_scan t=%0d: got %h want %h", t_o, obs_o, exp_o());
      end
    end
    tests++;
    if (fs_cnt != 1) begin fails++; $display("FAIL small_fs_per_frame: got %0d want 1", fs_cnt); end
    tests++;
    if (vs_low != 90) begin fails++; $display("FAIL small_vs_width: got %0d want 90", vs_low); end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    while (bus_b.horz != 10'd700 && n < 4000) begin tick(); n++; end
    tests++;
    if (n >= 4000) begin fails++; $display("FAIL mr_wait700: got timeout want horz=700"); return; end
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    tests++;
    if (bus_b.horz !== 10'd0 || bus_b.vert !== 10'd0 || bus_b.hsync !== 1'b1 ||
        bus_b.vsync !== 1'b1 || bus_b.rgb !== 8'h00) begin
      fails++;
      $display("FAIL mr_big_out: got h=%0d v=%0d hs=%b vs=%b rgb=%h want 0 0 1 1 00",
               bus_b.horz, bus_b.vert, bus_b.hsync, bus_b.vsync, bus_b.rgb);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      tests++;
      if (obs_b !== exp_b()) begin
        fails++;
        $display("FAIL mr_big_restart t=%0d: got %h want %h", t_b, obs_b, exp_b());
      end
    end
    // Reset the reduced instance inside its vsync pulse.
    n = 0;
    while (!(bus_s.vert == 10'd5 && bus_s.horz == 10'd10) && n < 500) begin tick(); n++; end
    tests++;
    if (n >= 500 || bus_s.vsync !== 1'b0) begin
      fails++;
      $display("FAIL mr_small_pre: got vsync=%b wait=%0d want vsync=0", bus_s.vsync, n);
    end
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    tests++;
    if (bus_s.horz !== 10'd0 || bus_s.vert !== 10'd0 || bus_s.vsync !== 1'b1 ||
        bus_s.hsync !== 1'b1 || bus_s.rgb !== 8'h00) begin
      fails++;
      $display("FAIL mr_small_out: got h=%0d v=%0d hs=%b vs=%b rgb=%h want 0 0 1 1 00",
               bus_s.horz, bus_s.vert, bus_s.hsync, bus_s.vsync, bus_s.rgb);
    end
    for (int i = 0; i < 400; i++) begin
      tick();
      tests++;
      if (obs_s !== exp_s()) begin
        fails++;
        $display("FAIL mr_small_restart t=%0d: got %h want %h", t_s, obs_s, exp_s());
      end
    end
  endtask

  task automatic test_frame_cnt();
`ifdef VGA_SCAN_FRAME_CNT_EN
    int n;
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (bus_s.frame_start !== 1'b1 && n < 500) begin tick(); n++; end
      tests++;
      if (n >= 500 || bus_s.frame_cnt !== 16'(k)) begin
        fails++;
        $display("FAIL frame_cnt%0d: got %0d (wait %0d) want %0d", k, bus_s.frame_cnt, n, k);
      end
      tick();
    end
`endif
  endtask

  initial begin
    rst_b = 1'b1;
    rst_s = 1'b1;
    rst_o = 1'b1;
    bus_b.img_in = 8'h00;
    bus_s.img_in = 8'h00;
    bus_o.img_in = 8'h00;
    test_reset();
    test_big_scan();
    test_hsync_line();
    test_blank_ff();
    test_small_frames();
    test_mid_reset();
    test_frame_cnt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Scan-timing initiator for the display path; generates the horz/vert coordinates consumed by every draw_* module.
- Produces VGA hsync/vsync for 640x480@60.
- Takes the merged 8-bit pixel returned by the draw/ROM layer and emits it aligned with the syncs.
- Blanks the pixel outside the visible region.

Parameters:
- CLK_DIV, 4, system clocks per pixel; 100 MHz clk -> 25 MHz pixel rate; legal values 1..15.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync pulse width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_VIS, 480, visible lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync pulse width, in lines.
- V_BP, 33, vertical back porch, in lines.
- PIPE_DLY, 1, clk cycles between horz/vert and a valid img_in (draw ROM read latency); legal values 0..4.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- horz  out  10  current pixel column; 0..H_total-1 (H_total = 800)
- vert  out  10  current line; 0..V_total-1 (V_total = 525)
- pix_en  out  1  one-clk pulse at the start of each pixel period
- frame_start  out  1  one-clk pulse on the pix_en where horz=0 and vert=0
- img_in  in  8  merged pixel from the draw layer, valid PIPE_DLY clks after horz/vert
- rgb  out  8  pixel to DAC; forced to 0 while blanked
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync

Behaviour:
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div_cnt == CLK_DIV-1), registered.
  - With CLK_DIV=1, pix_en is constantly 1 after reset.
- Horizontal counter: on pix_en, horz increments; at horz = H_total-1 it wraps to 0 and vert advances.
- Vertical counter: wraps from V_total-1 to 0 on the same pix_en where horz wraps.
- Counters are held (no change) between pix_en pulses.
- Derived signals, raw (undelayed, from current horz/vert):
  - blank_r = (horz >= H_VIS) || (vert >= V_VIS)
  - hs_r = ~(horz in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1]), i.e. low for 656..751
  - vs_r = ~(vert in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1]), i.e. low for 490..491
- Alignment pipeline:
  - blank_r, hs_r and vs_r pass through a PIPE_DLY-deep shift register clocked every clk, not only on pix_en.
  - Output stage, every clk:
    - rgb <= blank_d ? 8'h00 : img_in
    - hsync <= hs_d
    - vsync <= vs_d
  - Total latency from a horz/vert change to the corresponding rgb/hsync/vsync: PIPE_DLY+1 clks.
  - hsync and vsync therefore stay phase-aligned with rgb.
- frame_start is asserted with the same timing as pix_en (undelayed); draw modules use it for per-frame updates.
- Reset, while asserted and on the first clk after release:
  - Registers: div_cnt=0, horz=0, vert=0, pix_en=0, frame_start=0.
  - Delay-line stages: blank=1, hs=1, vs=1.
  - Outputs: rgb=0, hsync=1, vsync=1.
- First pix_en occurs CLK_DIV clks after reset deasserts.
  - The first pix_en does not advance horz; it marks pixel (0,0) and asserts frame_start.
  - Counting begins on the second pix_en.
- Reset mid-frame: counters return to (0,0) on the next edge; no partial sync pulse is stretched, because hsync/vsync are forced high by the reset.
- Boundary checks:
  - At (799, 524) the next pix_en yields (0, 0) with frame_start=1.
  - At (799, n<524) it yields (0, n+1).
- Widths: counter compares use 10-bit unsigned arithmetic; parameter sums must be < 1024.

Optional Feature:
- Macro: VGA_SCAN_FRAME_CNT_EN.
- When defined:
  - Adds output port frame_cnt [15:0], reset to 0.
  - frame_cnt increments by 1 on every frame_start pulse except the first one after reset, so the first frame reads 0.
  - Wraps 16'hFFFF -> 0.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset release, CLK_DIV=4 -> pix_en first high on clk 4 after release; frame_start high on that same cycle; horz=0, vert=0; rgb=0, hsync=1, vsync=1.
- Run one line -> hsync low for exactly 96*4=384 clks, starting (PIPE_DLY+1) clks after horz becomes 656; line period 3200 clks.
- Run one frame -> vsync low for exactly 2*800*4=6400 clks, starting when vert=490; frame period 1,680,000 clks; frame_start pulses once per frame.
- img_in tied 8'hFF, PIPE_DLY=1 -> rgb=8'hFF exactly while delayed horz<640 and vert<480; rgb=0 at horz 640..799 and at vert 480..524.
- Assert reset for 1 clk at horz=700, vert=300 -> next clk horz=0, vert=0, hsync=1, vsync=1, rgb=0; timing then restarts as in the first scenario.
- With VGA_SCAN_FRAME_CNT_EN defined, run 3 frames -> frame_cnt reads 0, 1, 2 on successive frame_start pulses; without the macro the build elaborates with no frame_cnt port.
